// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: opcode/funct fields, ALU
// operation codes, FSM states and decoded instruction classes.
package multicycle_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_NOR = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    typedef enum logic [2:0] {
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_RTYPE,
        CLS_IALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BEQ,
        CLS_BNE,
        CLS_JUMP
    } cls_e;

endpackage

// File: rtl/multicycle_controller_alu_op_decode.sv
// Combinational instruction decode: opcode/funct to ALU operation code,
// instruction class and an illegal flag for unsupported encodings.
module alu_op_decode
    import multicycle_controller_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int ALUOP_W = 4
) (
    input  logic [OPC_W-1:0]   opcode_i,
    input  logic [OPC_W-1:0]   funct_i,
    output logic [ALUOP_W-1:0] aluop_o,
    output cls_e               cls_o,
    output logic               illegal_o
);

    always_comb begin
        aluop_o   = '0;
        cls_o     = CLS_NONE;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_W'(OP_RTYPE): begin
                cls_o = CLS_RTYPE;
                case (funct_i)
                    OPC_W'(FN_ADD): aluop_o = ALUOP_W'(ALU_ADD);
                    OPC_W'(FN_SUB): aluop_o = ALUOP_W'(ALU_SUB);
                    OPC_W'(FN_AND): aluop_o = ALUOP_W'(ALU_AND);
                    OPC_W'(FN_OR):  aluop_o = ALUOP_W'(ALU_OR);
                    OPC_W'(FN_XOR): aluop_o = ALUOP_W'(ALU_XOR);
                    OPC_W'(FN_NOR): aluop_o = ALUOP_W'(ALU_NOR);
                    OPC_W'(FN_SLT): aluop_o = ALUOP_W'(ALU_SLT);
                    OPC_W'(FN_SLL): aluop_o = ALUOP_W'(ALU_SLL);
                    OPC_W'(FN_SRL): aluop_o = ALUOP_W'(ALU_SRL);
                    default: begin
                        cls_o     = CLS_NONE;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            OPC_W'(OP_ADDI): begin
                cls_o   = CLS_IALU;
                aluop_o = ALUOP_W'(ALU_ADD);
            end
            OPC_W'(OP_ANDI): begin
                cls_o   = CLS_IALU;
                aluop_o = ALUOP_W'(ALU_AND);
            end
            OPC_W'(OP_ORI): begin
                cls_o   = CLS_IALU;
                aluop_o = ALUOP_W'(ALU_OR);
            end
            // Loads/stores compute base+offset; branches compare by subtraction.
            OPC_W'(OP_LW): begin
                cls_o   = CLS_LOAD;
                aluop_o = ALUOP_W'(ALU_ADD);
            end
            OPC_W'(OP_SW): begin
                cls_o   = CLS_STORE;
                aluop_o = ALUOP_W'(ALU_ADD);
            end
            OPC_W'(OP_BEQ): begin
                cls_o   = CLS_BEQ;
                aluop_o = ALUOP_W'(ALU_SUB);
            end
            OPC_W'(OP_BNE): begin
                cls_o   = CLS_BNE;
                aluop_o = ALUOP_W'(ALU_SUB);
            end
            OPC_W'(OP_J): begin
                cls_o   = CLS_JUMP;
                aluop_o = ALUOP_W'(ALU_NOP);
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM (IF/ID/EX/MEM/WB/HALT) producing Moore datapath
// strobes; only the branch pc_write in EX follows the Zero input directly.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [OPC_W-1:0]   funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic               alu_src_imm,
    output logic               reg_dst_rd,
    output logic               mem_to_reg,
    output logic               pc_src_branch,
    output logic               pc_src_jump,
    output logic               illegal
);

    state_e               state_q, state_d;
    cls_e                 cls_q, cls_d;
    logic [ALUOP_W-1:0]   aluop_q, aluop_d;
    logic                 illegal_q, illegal_d;

    logic [ALUOP_W-1:0]   dec_aluop;
    cls_e                 dec_cls;
    logic                 dec_illegal;

    alu_op_decode #(
        .OPC_W   (OPC_W),
        .ALUOP_W (ALUOP_W)
    ) u_dec (
        .opcode_i  (opcode),
        .funct_i   (funct),
        .aluop_o   (dec_aluop),
        .cls_o     (dec_cls),
        .illegal_o (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IF;
            cls_q     <= CLS_NONE;
            aluop_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            aluop_q   <= aluop_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        aluop_d       = aluop_q;
        illegal_d     = illegal_q;
        ALUOp         = '0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        alu_src_imm   = 1'b0;
        reg_dst_rd    = 1'b0;
        mem_to_reg    = 1'b0;
        pc_src_branch = 1'b0;
        pc_src_jump   = 1'b0;
        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                ALUOp    = ALUOP_W'(ALU_ADD);
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                cls_d   = dec_cls;
                aluop_d = dec_aluop;
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                ALUOp   = aluop_q;
                state_d = S_IF;
                case (cls_q)
                    CLS_RTYPE: state_d = S_WB;
                    CLS_IALU: begin
                        alu_src_imm = 1'b1;
                        state_d     = S_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_imm = 1'b1;
                        state_d     = S_MEM;
                    end
                    CLS_BEQ: begin
                        pc_src_branch = 1'b1;
                        pc_write      = Zero;
                    end
                    CLS_BNE: begin
                        pc_src_branch = 1'b1;
                        pc_write      = ~Zero;
                    end
                    CLS_JUMP: begin
                        pc_src_jump = 1'b1;
                        pc_write    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (cls_q == CLS_STORE) begin
                    mem_write = 1'b1;
                end else begin
                    mem_read = 1'b1;
                end
                if (mem_ready) begin
                    state_d = (cls_q == CLS_STORE) ? S_IF : S_WB;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst_rd = (cls_q == CLS_RTYPE);
                mem_to_reg = (cls_q == CLS_LOAD);
                state_d    = S_IF;
            end
            S_HALT: ;
            default: state_d = S_IF;
        endcase
        // Strobes must drop the instant reset asserts, not at the next edge,
        // so an in-flight store never sees a late mem_write.
        if (!rst) begin
            ALUOp         = '0;
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            alu_src_imm   = 1'b0;
            reg_dst_rd    = 1'b0;
            mem_to_reg    = 1'b0;
            pc_src_branch = 1'b0;
            pc_src_jump   = 1'b0;
        end
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected outputs derived
// from instruction-level timing rules, plus literal pins on key cycles.
module tb_multicycle_controller;

    typedef struct packed {
        logic [3:0] aluop;
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src_imm;
        logic       reg_dst_rd;
        logic       mem_to_reg;
        logic       pc_src_branch;
        logic       pc_src_jump;
        logic       illegal;
    } outv_t;

    localparam int K_ILL = 0;
    localparam int K_R   = 1;
    localparam int K_I   = 2;
    localparam int K_LW  = 3;
    localparam int K_SW  = 4;
    localparam int K_BEQ = 5;
    localparam int K_BNE = 6;
    localparam int K_J   = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       Zero, mem_ready;
    logic [3:0] ALUOp;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic       alu_src_imm, reg_dst_rd, mem_to_reg, pc_src_branch, pc_src_jump;
    logic       illegal;

    outv_t      act;
    outv_t      ce;
    outv_t      exp_q[$];
    string      tag = "";
    int         checks = 0;
    int         errors = 0;

    // R-type funct values listed in ALU-code order: code = index + 1.
    logic [5:0] r_fn [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};

    multicycle_controller #(
        .OPC_W   (6),
        .ALUOP_W (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .funct         (funct),
        .Zero          (Zero),
        .mem_ready     (mem_ready),
        .ALUOp         (ALUOp),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .alu_src_imm   (alu_src_imm),
        .reg_dst_rd    (reg_dst_rd),
        .mem_to_reg    (mem_to_reg),
        .pc_src_branch (pc_src_branch),
        .pc_src_jump   (pc_src_jump),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    always_comb act = {ALUOp, pc_write, ir_write, mem_read, mem_write, reg_write,
                       alu_src_imm, reg_dst_rd, mem_to_reg, pc_src_branch, pc_src_jump, illegal};

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            checks++;
            if (act !== ce) begin
                errors++;
                $display("FAIL %s: got %b want %b", tag, act, ce);
            end
        end
    end

    function automatic void spec_decode(input logic [5:0] op, input logic [5:0] fn,
                                        output int kind, output logic [3:0] code);
        kind = K_ILL;
        code = 4'd0;
        case (op)
            6'h00: for (int i = 0; i < 9; i++) begin
                       if (r_fn[i] == fn) begin
                           kind = K_R;
                           code = 4'(i + 1);
                       end
                   end
            6'h08: begin kind = K_I;   code = 4'd1; end
            6'h0C: begin kind = K_I;   code = 4'd3; end
            6'h0D: begin kind = K_I;   code = 4'd4; end
            6'h23: begin kind = K_LW;  code = 4'd1; end
            6'h2B: begin kind = K_SW;  code = 4'd1; end
            6'h04: begin kind = K_BEQ; code = 4'd2; end
            6'h05: begin kind = K_BNE; code = 4'd2; end
            6'h02: begin kind = K_J;   code = 4'd0; end
            default: ;
        endcase
    endfunction

    task automatic check_now(input string name, input outv_t e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, e);
        end
    endtask

    task automatic cyc(input string name, input outv_t e);
        tag = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        Zero   = 1'($urandom);
    endtask

    task automatic reset_pulse(input string name);
        rst = 1'b0;
        #1;
        check_now({name, " reset outputs"}, '0);
        @(posedge clk);
        #1;
        check_now({name, " held in reset"}, '0);
        rst = 1'b1;
    endtask

    // abort_mem >= 0 asserts reset during that MEM cycle instead of completing it.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int if_wait, input int mem_wait,
                             input int abort_mem, input logic [3:0] pin_alu,
                             input logic pin_pcw, input int pin_lat);
        int         kind;
        logic [3:0] code;
        outv_t      e;
        int         n;
        n = 0;
        spec_decode(op, fn, kind, code);

        for (int i = 0; i <= if_wait; i++) begin
            scramble();
            mem_ready = (i == if_wait);
            e = '0;
            e.aluop = 4'd1;
            e.mem_read = 1'b1;
            e.ir_write = mem_ready;
            e.pc_write = mem_ready;
            cyc({name, " IF"}, e);
            n++;
        end

        opcode    = op;
        funct     = fn;
        mem_ready = 1'($urandom);
        cyc({name, " ID"}, '0);
        n++;
        scramble();

        if (kind == K_ILL) begin
            for (int i = 0; i < 4; i++) begin
                mem_ready = 1'($urandom);
                scramble();
                e = '0;
                e.illegal = 1'b1;
                cyc({name, " HALT"}, e);
            end
            return;
        end

        Zero      = z;
        mem_ready = 1'($urandom);
        e = '0;
        e.aluop = code;
        case (kind)
            K_I, K_LW, K_SW: e.alu_src_imm = 1'b1;
            K_BEQ: begin e.pc_src_branch = 1'b1; e.pc_write = z;  end
            K_BNE: begin e.pc_src_branch = 1'b1; e.pc_write = !z; end
            K_J:   begin e.pc_src_jump = 1'b1;   e.pc_write = 1'b1; end
            default: ;
        endcase
        tag = {name, " EX"};
        exp_q.push_back(e);
        #2;
        checks++;
        if (ALUOp !== pin_alu) begin
            errors++;
            $display("FAIL %s EX ALUOp literal: got %b want %b", name, ALUOp, pin_alu);
        end
        checks++;
        if (pc_write !== pin_pcw) begin
            errors++;
            $display("FAIL %s EX pc_write literal: got %b want %b", name, pc_write, pin_pcw);
        end
        @(posedge clk);
        #1;
        n++;
        scramble();

        if (kind == K_LW || kind == K_SW) begin
            for (int i = 0; i <= mem_wait; i++) begin
                if (i == abort_mem) begin
                    mem_ready = 1'b0;
                    #1;
                    rst = 1'b0;
                    #1;
                    check_now({name, " MEM reset immediate"}, '0);
                    #3;
                    check_now({name, " MEM reset no mem_write"}, '0);
                    @(posedge clk);
                    #1;
                    check_now({name, " MEM reset held"}, '0);
                    rst = 1'b1;
                    return;
                end
                mem_ready = (i == mem_wait);
                e = '0;
                e.mem_read  = (kind == K_LW);
                e.mem_write = (kind == K_SW);
                cyc({name, " MEM"}, e);
                n++;
            end
        end

        if (kind == K_R || kind == K_I || kind == K_LW) begin
            mem_ready = 1'($urandom);
            e = '0;
            e.reg_write  = 1'b1;
            e.reg_dst_rd = (kind == K_R);
            e.mem_to_reg = (kind == K_LW);
            cyc({name, " WB"}, e);
            n++;
        end

        if (pin_lat >= 0) begin
            checks++;
            if (n != pin_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", name, n, pin_lat);
            end
        end
    endtask

    initial begin
        outv_t e;
        rst       = 1'b0;
        opcode    = '0;
        funct     = '0;
        Zero      = 1'b0;
        mem_ready = 1'b0;
        #3;
        check_now("reset state", '0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        //        name    op     fn     Z     ifw mw abort alu       pcw   lat
        run_instr("add",  6'h00, 6'h20, 1'b0, 0, 0, -1, 4'b0001, 1'b0, 4);
        run_instr("lw",   6'h23, 6'h15, 1'b0, 0, 2, -1, 4'b0001, 1'b0, 7);
        run_instr("beq",  6'h04, 6'h00, 1'b1, 0, 0, -1, 4'b0010, 1'b1, 3);
        run_instr("bne",  6'h05, 6'h00, 1'b1, 0, 0, -1, 4'b0010, 1'b0, 3);
        run_instr("bne0", 6'h05, 6'h11, 1'b0, 0, 0, -1, 4'b0010, 1'b1, 3);
        run_instr("beq0", 6'h04, 6'h2A, 1'b0, 0, 0, -1, 4'b0010, 1'b0, 3);
        run_instr("addi", 6'h08, 6'h3F, 1'b0, 2, 0, -1, 4'b0001, 1'b0, 6);
        run_instr("andi", 6'h0C, 6'h00, 1'b0, 0, 0, -1, 4'b0011, 1'b0, 4);
        run_instr("ori",  6'h0D, 6'h22, 1'b0, 0, 0, -1, 4'b0100, 1'b0, 4);
        run_instr("sw",   6'h2B, 6'h01, 1'b0, 0, 1, -1, 4'b0001, 1'b0, 5);
        run_instr("sub",  6'h00, 6'h22, 1'b0, 0, 0, -1, 4'b0010, 1'b0, 4);
        run_instr("and",  6'h00, 6'h24, 1'b0, 1, 0, -1, 4'b0011, 1'b0, 5);
        run_instr("or",   6'h00, 6'h25, 1'b0, 0, 0, -1, 4'b0100, 1'b0, 4);
        run_instr("xor",  6'h00, 6'h26, 1'b0, 0, 0, -1, 4'b0101, 1'b0, 4);
        run_instr("nor",  6'h00, 6'h27, 1'b0, 0, 0, -1, 4'b0110, 1'b0, 4);
        run_instr("slt",  6'h00, 6'h2A, 1'b0, 0, 0, -1, 4'b0111, 1'b0, 4);
        run_instr("sll",  6'h00, 6'h00, 1'b0, 0, 0, -1, 4'b1000, 1'b0, 4);
        run_instr("srl",  6'h00, 6'h02, 1'b0, 0, 0, -1, 4'b1001, 1'b0, 4);
        run_instr("j",    6'h02, 6'h02, 1'b0, 0, 0, -1, 4'b0000, 1'b1, 3);
        run_instr("lw0",  6'h23, 6'h00, 1'b1, 0, 0, -1, 4'b0001, 1'b0, 5);

        run_instr("sw_abort", 6'h2B, 6'h00, 1'b0, 0, 3, 1, 4'b0001, 1'b0, -1);
        run_instr("post_rst_add", 6'h00, 6'h20, 1'b0, 0, 0, -1, 4'b0001, 1'b0, 4);

        run_instr("ill_op", 6'h3F, 6'h20, 1'b0, 0, 0, -1, 4'b0000, 1'b0, -1);
        reset_pulse("ill_op");
        run_instr("ill_fn", 6'h00, 6'h3F, 1'b0, 0, 0, -1, 4'b0000, 1'b0, -1);
        reset_pulse("ill_fn");
        run_instr("post_halt_j", 6'h02, 6'h00, 1'b0, 0, 0, -1, 4'b0000, 1'b1, 3);

        scramble();
        mem_ready = 1'b0;
        e = '0;
        e.aluop = 4'd1;
        e.mem_read = 1'b1;
        cyc("final IF", e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter OPC_W, default 6, width of opcode and funct fields.
REQ-002 Parameter ALUOP_W, default 4, width of ALUOp output; matches the datapath ALU operation code.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
REQ-005 opcode  input  OPC_W  instruction[31:26], sampled only in ID.
REQ-006 funct  input  OPC_W  instruction[5:0], sampled only in ID.
REQ-007 Zero  input  1  ALU zero flag, sampled only in EX of a branch.
REQ-008 mem_ready  input  1  memory handshake; access completes in a cycle with mem_ready=1.
REQ-009 ALUOp  output  ALUOP_W  ALU code: 0000 nop, 0001 add, 0010 sub, 0011 and, 0100 or, 0101 xor, 0110 nor, 0111 slt, 1000 sll, 1001 srl.
REQ-010 pc_write, ir_write, mem_read, mem_write, reg_write  output  1 each  datapath strobes.
REQ-011 alu_src_imm, reg_dst_rd, mem_to_reg, pc_src_branch, pc_src_jump  output  1 each  datapath mux selects.
REQ-012 illegal  output  1  sticky: unsupported opcode/funct decoded.

Function
REQ-013 States SHALL be IF, ID, EX, MEM, WB, HALT; Moore outputs only, except pc_write in EX of a branch (REQ-020).
REQ-014 IF: mem_read=1, ALUOp=0001; ir_write=pc_write=1 only in the cycle mem_ready=1, then -> ID; else hold in IF.
REQ-015 ID: decode opcode/funct into a registered class/op; all strobes 0; -> EX, or -> HALT if illegal.
REQ-016 R-type (opcode 0): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x00 sll, 0x02 srl; EX drives mapped ALUOp with alu_src_imm=0; WB reg_write=1, reg_dst_rd=1, mem_to_reg=0.
REQ-017 I-type ALU: 0x08 addi->0001, 0x0C andi->0011, 0x0D ori->0100; EX alu_src_imm=1; WB reg_write=1, reg_dst_rd=0.
REQ-018 lw 0x23: EX ALUOp=0001, alu_src_imm=1 -> MEM (mem_read=1, stall until mem_ready) -> WB (reg_write=1, mem_to_reg=1).
REQ-019 sw 0x2B: EX as lw -> MEM (mem_write=1, stall until mem_ready) -> IF; no WB.
REQ-020 beq 0x04 / bne 0x05: EX ALUOp=0010, pc_src_branch=1, pc_write=Zero (beq) or ~Zero (bne); -> IF.
REQ-021 j 0x02: EX pc_src_jump=1, pc_write=1, ALUOp=0000; -> IF.
REQ-022 Latency without stalls: R/I-ALU 4, lw 5, sw 4, branch 3, j 3 cycles; each mem_ready=0 cycle in IF/MEM adds one.
REQ-023 WB SHALL always return to IF; at most one of mem_read/mem_write asserted in any cycle.
REQ-024 HALT: all strobes 0, ALUOp=0000, illegal=1; remains until reset.
REQ-025 Outside active states all strobes and selects SHALL be 0 and ALUOp=0000.

Reset
REQ-026 rst=0 SHALL force state IF, decoded registers 0, illegal=0, all strobes 0 asynchronously.
REQ-027 First cycle after rst release SHALL be IF; reset mid-MEM aborts the access with no mem_write pulse after assertion.

Structure
REQ-028 Shared package holds opcode/funct constants, ALUOp codes, and the state enumeration; the ALU uses the same ALUOp constants.
REQ-029 One sub-module, alu_op_decode (combinational opcode/funct -> ALUOp, class, illegal), instantiated by the FSM.

Verification
REQ-030 add (opcode 0, funct 0x20), mem_ready=1 -> states IF,ID,EX,WB; ALUOp=0001 in EX; reg_write=1, reg_dst_rd=1 in WB only.
REQ-031 lw (0x23) with mem_ready=0 for 2 MEM cycles -> mem_read held 3 MEM cycles, total 7 cycles, mem_to_reg=1 in WB.
REQ-032 beq with Zero=1 -> pc_write=1 in EX; bne with Zero=1 -> pc_write=0; both ALUOp=0010, 3 cycles.
REQ-033 opcode 0x3F -> HALT after ID, illegal=1 sticky, all strobes 0 until rst=0.
REQ-034 sw with rst asserted mid-MEM -> outputs 0 at once, IF with mem_read=1 in first cycle after release.
REQ-035 srl (funct 0x02) then j (0x02) back-to-back -> ALUOp 1001 then 0000 with pc_src_jump=1, pc_write=1 in j EX.
